// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file write-back producer.
// Aligns big-endian load data, including LWL/LWR partial-lane writes, and counts retired instructions.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_wr,
    input  logic             mem_to_reg,
    input  logic [2:0]       mem_load_type,
    input  logic [1:0]       mem_byte_off,
    input  logic [4:0]       mem_rd_addr,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_rdata,
    output logic [4:0]       Rd_addr,
    output logic [31:0]      Rd_in,
    output logic             RegWr,
    output logic [3:0]       Rd_Byte_w_en,
    output logic             wb_valid,
    output logic [4:0]       fwd_addr,
    output logic [31:0]      fwd_data,
    output logic             fwd_en,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LWL = 3'd5;
    localparam logic [2:0] LD_LWR = 3'd6;

    logic             capture;
    logic [7:0]       lane [4];
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;
    logic [3:0]       load_en;

    logic [4:0]       rd_addr_next, rd_addr_reg;
    logic [31:0]      rd_in_next, rd_in_reg;
    logic             reg_wr_next, reg_wr_reg;
    logic [3:0]       byte_en_next, byte_en_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] retired_next, retired_reg;

    assign capture = mem_valid & ~stall & ~flush;

    // Lane k is the k-th byte in big-endian address order.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_rdata[31-8*gi -: 8];
        end
    endgenerate

    assign byte_sel = lane[mem_byte_off];
    assign half_sel = mem_byte_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    always_comb begin
        load_data = mem_rdata;
        load_en   = 4'b1111;
        case (mem_load_type)
            LD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: load_data = {24'h0, byte_sel};
            LD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LD_LHU: load_data = {16'h0, half_sel};
            // 3-off equals ~off for a 2-bit offset.
            LD_LWL: begin
                load_data = mem_rdata << {mem_byte_off, 3'b000};
                load_en   = 4'b1111 << mem_byte_off;
            end
            LD_LWR: begin
                load_data = mem_rdata >> {~mem_byte_off, 3'b000};
                load_en   = 4'b1111 >> (~mem_byte_off);
            end
            default: begin
                load_data = mem_rdata;
                load_en   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rd_addr_next = 5'd0;
        rd_in_next   = 32'd0;
        reg_wr_next  = 1'b0;
        byte_en_next = 4'b0000;
        retired_next = retired_reg;
        if (capture) begin
            rd_addr_next = mem_rd_addr;
            rd_in_next   = mem_to_reg ? load_data : mem_alu_result;
            reg_wr_next  = mem_reg_wr & (mem_rd_addr != 5'd0);
            byte_en_next = reg_wr_next ? (mem_to_reg ? load_en : 4'b1111) : 4'b0000;
            retired_next = retired_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_reg <= 5'd0;
            rd_in_reg   <= 32'd0;
            reg_wr_reg  <= 1'b0;
            byte_en_reg <= 4'b0000;
            valid_reg   <= 1'b0;
            retired_reg <= '0;
        end else begin
            rd_addr_reg <= rd_addr_next;
            rd_in_reg   <= rd_in_next;
            reg_wr_reg  <= reg_wr_next;
            byte_en_reg <= byte_en_next;
            valid_reg   <= capture;
            retired_reg <= retired_next;
        end
    end

    assign Rd_addr      = rd_addr_reg;
    assign Rd_in        = rd_in_reg;
    assign RegWr        = reg_wr_reg;
    assign Rd_Byte_w_en = byte_en_reg;
    assign wb_valid     = valid_reg;
    assign fwd_addr     = rd_addr_reg;
    assign fwd_data     = rd_in_reg;
    assign fwd_en       = reg_wr_reg;
    assign retired      = retired_reg;

endmodule
